pll_prog_seq: RTL

Programming sequencer that sits directly upstream of the PLL wrapper and drives its functional-mode control inputs (`func_*`) from the `refclk` domain. It accepts a PLL configuration through a valid/ready handshake. It then walks the PLL through a safe sequence: switch the output to refclk, hold reset while applying dividers, wait for lock, switch back to the PLL clock, and flag `prog_done`. It also records reference/feedback slip events reported by the PLL.

---
 rtl/pll_prog_seq_pkg.sv | 36 +++
 rtl/sync.sv | 28 ++
 rtl/pll_prog_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pll_prog_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_prog_seq_pkg : shared types for the PLL programming sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pll_prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SWITCH_OUT = 3'd1,
    PWRDN      = 3'd2,
    RESET      = 3'd3,
    LOCK       = 3'd4,
    SWITCH_IN  = 3'd5,
    DONE       = 3'd6
  } pll_seq_state_e;

  typedef struct packed {
    logic [3:0] clkr;
    logic [5:0] clkf;
    logic [3:0] clkod;
    logic [5:0] bwadj;
    logic       bypass;
    logic       pwrdn;
  } pll_cfg_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync.sv
// ---------------------------------------------------------------------------
// sync : two-flop synchronizer for a single asynchronous level
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pll_prog_seq.sv
// ---------------------------------------------------------------------------
// pll_prog_seq : walks the PLL through switch-out / reset / lock / switch-in
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_prog_seq
  import pll_prog_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_CYCLES   = 2048,
  parameter int SWITCH_CYCLES = 8
) (
  input  logic       refclk,
  input  logic       rstn,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_clkr,
  input  logic [5:0] cfg_clkf,
  input  logic [3:0] cfg_clkod,
  input  logic [5:0] cfg_bwadj,
  input  logic       cfg_bypass,
  input  logic       cfg_pwrdn,
  output logic [3:0] func_clkr,
  output logic [5:0] func_clkf,
  output logic [3:0] func_clkod,
  output logic [5:0] func_bwadj,
  output logic       func_reset,
  output logic       func_intfb,
  output logic       func_bypass,
  output logic       func_test,
  output logic       func_pwrdn,
  output logic       func_clk_sel,
  output logic       func_prog_done,
  input  logic       rfslip,
  input  logic       fbslip,
  output logic       slip_sticky,
  output logic       busy
);

  localparam int CNT_W = $clog2(max3(RESET_CYCLES, LOCK_CYCLES, SWITCH_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_CYCLES - 1);

  pll_seq_state_e   state;
  pll_seq_state_e   state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic             accept;
  logic             cnt_zero;
  logic             pwrdn_req;
  logic             rfslip_s;
  logic             fbslip_s;
  pll_cfg_t         cfg_in;

  assign cfg_in     = {cfg_clkr, cfg_clkf, cfg_clkod, cfg_bwadj, cfg_bypass, cfg_pwrdn};
  assign cfg_ready  = (state == IDLE) || (state == DONE);
  assign busy       = !cfg_ready;
  assign accept     = cfg_valid && cfg_ready;
  assign cnt_zero   = (cnt == '0);
  assign func_intfb = 1'b1;
  assign func_test  = 1'b0;

  sync u_rfslip_sync (
    .clk   (refclk),
    .rst_n (rstn),
    .d     (rfslip),
    .q     (rfslip_s)
  );

  sync u_fbslip_sync (
    .clk   (refclk),
    .rst_n (rstn),
    .d     (fbslip),
    .q     (fbslip_s)
  );

  // A fresh request from IDLE needs no switch-out: the output is already on refclk.
  always_comb begin
    state_d  = state;
    cnt_load = '0;
    case (state)
      IDLE:       if (accept) state_d = cfg_pwrdn ? PWRDN : RESET;
      DONE:       if (accept) state_d = SWITCH_OUT;
      SWITCH_OUT: if (cnt_zero) state_d = pwrdn_req ? PWRDN : RESET;
      PWRDN:      state_d = IDLE;
      RESET:      if (cnt_zero) state_d = func_bypass ? SWITCH_IN : LOCK;
      LOCK:       if (cnt_zero) state_d = SWITCH_IN;
      SWITCH_IN:  if (cnt_zero) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    case (state_d)
      SWITCH_OUT, SWITCH_IN: cnt_load = SWITCH_LOAD;
      RESET:                 cnt_load = RESET_LOAD;
      LOCK:                  cnt_load = LOCK_LOAD;
      default:               cnt_load = '0;
    endcase
  end

  always_ff @(posedge refclk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) begin
        cnt <= cnt_load;
      end else if (!cnt_zero) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Control outputs follow the state being entered so they line up with it.
  always_ff @(posedge refclk or negedge rstn) begin
    if (!rstn) begin
      func_clkr      <= '0;
      func_clkf      <= '0;
      func_clkod     <= '0;
      func_bwadj     <= '0;
      func_bypass    <= 1'b0;
      pwrdn_req      <= 1'b0;
      func_reset     <= 1'b1;
      func_pwrdn     <= 1'b0;
      func_clk_sel   <= 1'b0;
      func_prog_done <= 1'b0;
      slip_sticky    <= 1'b0;
    end else begin
      if (accept) begin
        func_clkr   <= cfg_in.clkr;
        func_clkf   <= cfg_in.clkf;
        func_clkod  <= cfg_in.clkod;
        func_bwadj  <= cfg_in.bwadj;
        func_bypass <= cfg_in.bypass;
        pwrdn_req   <= cfg_in.pwrdn;
      end
      func_prog_done <= (state_d == DONE);
      case (state_d)
        IDLE: begin
          func_reset   <= 1'b1;
          func_clk_sel <= 1'b0;
        end
        SWITCH_OUT: func_clk_sel <= 1'b0;
        RESET: begin
          func_reset <= 1'b1;
          func_pwrdn <= 1'b0;
        end
        LOCK:      func_reset   <= 1'b0;
        SWITCH_IN: func_clk_sel <= 1'b1;
        DONE: begin
          func_reset   <= 1'b0;
          func_clk_sel <= 1'b1;
        end
        default: ;
      endcase
      if (state == PWRDN) begin
        func_pwrdn <= 1'b1;
      end
      if (accept) begin
        slip_sticky <= 1'b0;
      end else if ((state == DONE) && (rfslip_s || fbslip_s)) begin
        slip_sticky <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
